// File: rtl/parking_occupancy_tracker_pkg.sv
// Shared defaults, spot-state encoding and the popcount helper for the
// parking occupancy tracker.
package parking_occupancy_tracker_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
   localparam int DEFAULT_STAT_W          = 16;
   localparam int MAX_SPOTS               = 64;

   typedef enum logic {
      SPOT_FREE     = 1'b0,
      SPOT_OCCUPIED = 1'b1
   } spot_state_e;

   // Counts set bits of a bus padded to the widest supported spot count.
   function automatic logic [6:0] popcount(input logic [MAX_SPOTS-1:0] v);
      logic [6:0] c;
      c = 7'd0;
      for (int i = 0; i < MAX_SPOTS; i++) begin
         c = c + {6'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/parking_occupancy_tracker_spot_debouncer.sv
// One parking spot: two-flop synchroniser, debounce counter and accepted state.
// rise/fall flag the edge on which the accepted state is about to flip.
module parking_occupancy_tracker_spot_debouncer
   import parking_occupancy_tracker_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   input  logic enable,
   output logic state,
   output logic rise,
   output logic fall
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_r;
   logic [CW-1:0] cnt_r;
   spot_state_e   state_r;
   logic          differ_s;
   logic          accept_s;

   // Acceptance decision for the current edge.
   always_comb begin
      differ_s = (sync_r[1] != state_r);
      accept_s = enable && differ_s && (cnt_r == CNT_LAST);
      rise     = accept_s && sync_r[1];
      fall     = accept_s && !sync_r[1];
   end

   // Synchroniser, debounce counter and accepted state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r  <= 2'b00;
         cnt_r   <= '0;
         state_r <= SPOT_FREE;
      end else begin
         sync_r <= {sync_r[0], raw};
         if (!enable || !differ_s) begin
            cnt_r <= '0;
         end else if (accept_s) begin
            cnt_r   <= '0;
            state_r <= spot_state_e'(sync_r[1]);
         end else begin
            cnt_r <= cnt_r + CW'(1'b1);
         end
      end
   end

   assign state = state_r;

endmodule

// File: rtl/parking_occupancy_tracker.sv
// Debounced occupancy tracker for N_SPOTS sensors: registered count, Full/Empty,
// arrival/departure pulses and saturating statistics.
module parking_occupancy_tracker
   import parking_occupancy_tracker_pkg::*;
#(
   parameter int N_SPOTS         = 8,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int STAT_W          = DEFAULT_STAT_W,
   localparam int CNT_W          = $clog2(N_SPOTS + 1)
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [N_SPOTS-1:0] In,
   input  logic               Enable,
   input  logic               Clear_stats,
   output logic [N_SPOTS-1:0] Occupied,
   output logic [CNT_W-1:0]   Qtd,
   output logic               Full,
   output logic               Empty,
   output logic               Arrival,
   output logic               Departure,
   output logic [STAT_W-1:0]  Arrivals_total,
   output logic [CNT_W-1:0]   Peak
);

   localparam int SUM_W = ((STAT_W > 7) ? STAT_W : 7) + 1;
   localparam logic [SUM_W-1:0] STAT_MAX = SUM_W'({STAT_W{1'b1}});

   logic [N_SPOTS-1:0]   rise_s;
   logic [N_SPOTS-1:0]   fall_s;
   logic [MAX_SPOTS-1:0] rise_pad_s;
   logic [MAX_SPOTS-1:0] fall_pad_s;
   logic [6:0]           r_s;
   logic [6:0]           f_s;
   logic [CNT_W-1:0]     qtd_next_s;
   logic [SUM_W-1:0]     sum_s;
   logic [STAT_W-1:0]    total_next_s;
   logic [CNT_W-1:0]     peak_next_s;

   for (genvar g = 0; g < N_SPOTS; g++) begin : g_spot
      parking_occupancy_tracker_spot_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_spot (
         .clk    (Clk),
         .reset_n(Reset_n),
         .raw    (In[g]),
         .enable (Enable),
         .state  (Occupied[g]),
         .rise   (rise_s[g]),
         .fall   (fall_s[g])
      );
   end

   // Next count and statistics; clear restarts accumulation from this cycle's events.
   always_comb begin
      rise_pad_s = '0;
      fall_pad_s = '0;
      rise_pad_s[N_SPOTS-1:0] = rise_s;
      fall_pad_s[N_SPOTS-1:0] = fall_s;
      r_s = popcount(rise_pad_s);
      f_s = popcount(fall_pad_s);
      qtd_next_s = Qtd + CNT_W'(r_s) - CNT_W'(f_s);

      if (Clear_stats) begin
         sum_s = SUM_W'(r_s);
      end else begin
         sum_s = SUM_W'(Arrivals_total) + SUM_W'(r_s);
      end
      if (sum_s > STAT_MAX) begin
         total_next_s = {STAT_W{1'b1}};
      end else begin
         total_next_s = STAT_W'(sum_s);
      end

      if (Clear_stats || (qtd_next_s > Peak)) begin
         peak_next_s = qtd_next_s;
      end else begin
         peak_next_s = Peak;
      end
   end

   // Count, flag, pulse and statistics registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Qtd            <= '0;
         Full           <= 1'b0;
         Empty          <= 1'b1;
         Arrival        <= 1'b0;
         Departure      <= 1'b0;
         Arrivals_total <= '0;
         Peak           <= '0;
      end else begin
         Qtd            <= qtd_next_s;
         Full           <= (qtd_next_s == CNT_W'(N_SPOTS));
         Empty          <= (qtd_next_s == '0);
         Arrival        <= (r_s != 7'd0);
         Departure      <= (f_s != 7'd0);
         Arrivals_total <= total_next_s;
         Peak           <= peak_next_s;
      end
   end

endmodule
